// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg: state encoding and lane sizing helpers shared by the
// external-memory bridge files.
package ext_mem_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, TURN, RDATA, DONE} state_t;

   function automatic int lanes(input int w, input int b);
      return w / b;
   endfunction

   function automatic int lane_w(input int aw, input int dw, input int b);
      int n;
      n = $clog2((aw > dw ? aw : dw) / b);
      return n < 1 ? 1 : n;
   endfunction

endpackage

// File: rtl/ext_mem_ack_sync.sv
// ext_mem_ack_sync: two-flop synchroniser for the asynchronous read acknowledge
// followed by a one-cycle rising-edge pulse.
module ext_mem_ack_sync (
   input  logic clk,
   input  logic reset,
   input  logic ack,
   output logic rise
);

   logic [2:0] sr;

   always_ff @(posedge clk)
      if (reset) sr <= '0;
      else sr <= {sr[1:0], ack};

   assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: lane-serial external memory bridge with valid/ready requests,
// programmable hold/turnaround timing and a timed-out read error response.
module ext_mem_bridge import ext_mem_pkg::*; #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int BUS_W = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int TURN_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int LANE_W = lane_w(ADDR_W, DATA_W, BUS_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error,
   output logic              ext_we,
   output logic              ext_re,
   output logic              ext_addr_phase,
   output logic              ext_strobe,
   output logic [LANE_W-1:0] ext_lane,
   output logic [BUS_W-1:0]  bus_out,
   output logic              bus_oe,
   input  logic [BUS_W-1:0]  bus_in,
   input  logic              ext_ack
);

   localparam int NA = lanes(ADDR_W, BUS_W);
   localparam int ND = lanes(DATA_W, BUS_W);
   localparam int CW = $clog2((HOLD_CYCLES > TURN_CYCLES ? HOLD_CYCLES : TURN_CYCLES) + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state, state_n;
   logic [LANE_W-1:0] lane, lane_n, lane_d;
   logic [CW-1:0]     cnt, cnt_n;
   logic [TW-1:0]     tmo, tmo_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic [BUS_W-1:0]  bus_d;
   logic              wr_q, wr_n, accept, rise, lane_end, capture, tmo_hit;
   logic              active, ready_d, we_d, re_d, aph_d, stb_d, oe_d, valid_d;

   ext_mem_ack_sync u_sync (.clk(clk), .reset(reset), .ack(ext_ack), .rise(rise));

   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         lane <= '0;
         cnt <= '0;
         tmo <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         wr_q <= 1'b0;
      end else begin
         state <= state_n;
         lane <= lane_n;
         cnt <= cnt_n;
         tmo <= tmo_n;
         addr_q <= addr_n;
         wdata_q <= wdata_n;
         wr_q <= wr_n;
      end

   // req_ready (registered) gates acceptance so the cycle right after reset cannot accept
   always_comb begin
      state_n = state;
      lane_n = lane;
      cnt_n = '0;
      tmo_n = '0;
      tmo_hit = 1'b0;
      accept = req_valid && req_ready;
      addr_n = accept ? req_addr : addr_q;
      wdata_n = accept ? req_wdata : wdata_q;
      wr_n = accept ? req_write : wr_q;
      lane_end = cnt == CW'(HOLD_CYCLES);
      capture = state == RDATA && rise;
      case (state)
         IDLE: begin
            state_n = accept ? ADDR : IDLE;
            lane_n = '0;
         end
         ADDR, WDATA: begin
            cnt_n = lane_end ? '0 : cnt + CW'(1);
            if (lane_end && lane == LANE_W'((state == ADDR ? NA : ND) - 1)) begin
               lane_n = '0;
               state_n = state == WDATA ? DONE : wr_q ? WDATA : TURN;
            end else if (lane_end)
               lane_n = lane + LANE_W'(1);
         end
         TURN: begin
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(TURN_CYCLES - 1)) begin
               cnt_n = '0;
               state_n = RDATA;
            end
         end
         RDATA: begin
            tmo_n = capture ? '0 : tmo + TW'(1);
            tmo_hit = !capture && tmo_n == TW'(TIMEOUT_CYCLES);
            if (capture && lane == LANE_W'(ND - 1)) begin
               lane_n = '0;
               state_n = DONE;
            end else if (capture)
               lane_n = lane + LANE_W'(1);
            else if (tmo_hit) begin
               lane_n = '0;
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Decoded from next-state values so the registered pins line up with the state
   always_comb begin
      active = state_n inside {ADDR, WDATA, TURN, RDATA};
      ready_d = state_n == IDLE;
      we_d = active && wr_n;
      re_d = active && !wr_n;
      aph_d = state_n == ADDR;
      oe_d = state_n inside {ADDR, WDATA};
      stb_d = oe_d || state_n == RDATA;
      lane_d = stb_d ? lane_n : '0;
      bus_d = aph_d ? BUS_W'(addr_n >> (int'(lane_n) * BUS_W)) :
              state_n == WDATA ? BUS_W'(wdata_n >> (int'(lane_n) * BUS_W)) : '0;
      valid_d = state_n == DONE;
   end

   always_ff @(posedge clk)
      if (reset) begin
         req_ready <= 1'b0;
         resp_valid <= 1'b0;
         ext_we <= 1'b0;
         ext_re <= 1'b0;
         ext_addr_phase <= 1'b0;
         ext_strobe <= 1'b0;
         ext_lane <= '0;
         bus_out <= '0;
         bus_oe <= 1'b0;
      end else begin
         req_ready <= ready_d;
         resp_valid <= valid_d;
         ext_we <= we_d;
         ext_re <= re_d;
         ext_addr_phase <= aph_d;
         ext_strobe <= stb_d;
         ext_lane <= lane_d;
         bus_out <= bus_d;
         bus_oe <= oe_d;
      end

   always_ff @(posedge clk)
      if (reset || accept) begin
         resp_rdata <= '0;
         resp_error <= 1'b0;
      end else begin
         if (capture) resp_rdata[int'(lane) * BUS_W +: BUS_W] <= bus_in;
         if (tmo_hit) resp_error <= 1'b1;
      end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// tb_ext_mem_bridge: directed and randomized checks of ext_mem_bridge at defaults and a 24/32-bit zero-hold instance
`define CHK(n, a, e) chk(n, 32'(a), 32'(e))
module tb_ext_mem_bridge;
  localparam int NA = 2, ND = 2, H = 4, TC = 2, TO = 255;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic        resp_valid, resp_error, ext_we, ext_re, ext_addr_phase, ext_strobe, bus_oe;
  logic [0:0]  ext_lane;
  logic [7:0]  bus_out, bus_in = '0;
  logic        ext_ack = 1'b0;
  logic        s_req_valid = 1'b0, s_req_ready, s_req_write = 1'b0;
  logic [23:0] s_req_addr = '0;
  logic [31:0] s_req_wdata = '0, s_resp_rdata;
  logic        s_resp_valid, s_resp_error, s_we, s_re, s_aph, s_stb, s_oe;
  logic [1:0]  s_lane;
  logic [7:0]  s_bus_out;
  logic [7:0]  s_exp;
  ext_mem_bridge dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ext_we(ext_we), .ext_re(ext_re), .ext_addr_phase(ext_addr_phase),
    .ext_strobe(ext_strobe), .ext_lane(ext_lane), .bus_out(bus_out),
    .bus_oe(bus_oe), .bus_in(bus_in), .ext_ack(ext_ack)
  );
  ext_mem_bridge #(.ADDR_W(24), .DATA_W(32), .BUS_W(8), .HOLD_CYCLES(0),
                   .TURN_CYCLES(2), .TIMEOUT_CYCLES(255)) swp (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_write(s_req_write), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_error(s_resp_error),
    .ext_we(s_we), .ext_re(s_re), .ext_addr_phase(s_aph),
    .ext_strobe(s_stb), .ext_lane(s_lane), .bus_out(s_bus_out),
    .bus_oe(s_oe), .bus_in(8'h00), .ext_ack(1'b0)
  );
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          nacks;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        stale;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];
  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] lane_of(input logic [31:0] v, input int l);
    return 8'(v >> (8 * l));
  endfunction
  function automatic logic [15:0] model_rd(input logic [7:0] b0, input logic [7:0] b1, input int n);
    return (n > 0 ? {8'h00, b0} : 16'h0000) | (n > 1 ? {b1, 8'h00} : 16'h0000);
  endfunction
  task automatic zero_outputs(input string nm);
    `CHK(nm, {req_ready, resp_valid, resp_error, ext_we, ext_re, ext_addr_phase,
              ext_strobe, ext_lane, bus_oe, bus_out}, 0);
    `CHK({nm, "_rdata"}, resp_rdata, 0);
  endtask
  task automatic request(input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    `CHK("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask
  task automatic addr_lanes(input logic wr, input logic [15:0] a);
    for (int k = 0; k < NA * (H + 1); k++) begin
      `CHK("addr_bus", bus_out, lane_of(32'(a), k / (H + 1)));
      `CHK("addr_oe", bus_oe, 1);
      `CHK("addr_phase", ext_addr_phase, 1);
      `CHK("addr_strobe", ext_strobe, 1);
      `CHK("addr_lane", ext_lane, k / (H + 1));
      `CHK("addr_dir", {ext_we, ext_re}, wr ? 2'b10 : 2'b01);
      `CHK("addr_ready", req_ready, 0);
      @(negedge clk);
    end
  endtask
  task automatic run_vec(input vec_t v);
    logic [15:0] prev;
    int last, c, p, base;
    ext_ack = v.stale;
    bus_in = 8'hEE;
    request(v.wr, v.addr, v.wdata);
    addr_lanes(v.wr, v.addr);
    if (v.wr) begin
      for (int k = 0; k < ND * (H + 1); k++) begin
        `CHK("data_bus", bus_out, lane_of(32'(v.wdata), k / (H + 1)));
        `CHK("data_oe", bus_oe, 1);
        `CHK("data_phase", ext_addr_phase, 0);
        `CHK("data_strobe", ext_strobe, 1);
        `CHK("data_lane", ext_lane, k / (H + 1));
        `CHK("data_dir", {ext_we, ext_re}, 2'b10);
        `CHK("data_valid", resp_valid, 0);
        @(negedge clk);
      end
    end else begin
      for (int k = 0; k < TC; k++) begin
        `CHK("turn_oe_bus_stb", {bus_oe, bus_out, ext_strobe}, 0);
        `CHK("turn_re", ext_re, 1);
        @(negedge clk);
      end
      `CHK("rd_entry", {ext_strobe, bus_oe, ext_lane, ext_re}, 4'b1001);
      prev = resp_rdata;
      last = 0;
      base = v.stale ? 10 : 0;
      for (c = 0; c < TO + 100 && !resp_valid; c++) begin
        if (resp_rdata !== prev) begin
          prev = resp_rdata;
          last = c;
        end
        p = c - base;
        if (c < base) begin
          ext_ack = c < 4;
          bus_in = 8'hEE;
        end else if (p / 7 < v.nacks) begin
          ext_ack = (p % 7) < 3;
          bus_in = (p / 7 == 0) ? v.b0 : v.b1;
        end else
          ext_ack = 1'b0;
        @(negedge clk);
      end
      `CHK("resp_wait", resp_valid, 1);
      if (v.nacks < ND) `CHK("timeout_gap", c - last, TO);
    end
    `CHK("resp_valid", resp_valid, 1);
    `CHK("resp_error", resp_error, v.exp_err);
    `CHK("resp_rdata", resp_rdata, v.exp_rdata);
    `CHK("done_pins", {ext_we, ext_re, ext_addr_phase, ext_strobe, bus_oe, bus_out}, 0);
    ext_ack = 1'b0;
    @(negedge clk);
    `CHK("valid_pulse", resp_valid, 0);
    `CHK("idle_ready", req_ready, 1);
    `CHK("rdata_hold", resp_rdata, v.exp_rdata);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vecs);
    $fatal(1);
  end
  initial begin
    vec_t v;
    tbl.push_back(vec_t'{1'b1, 16'hA55A, 16'h1234, 0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 16'h00F0, 16'h0000, 2, 8'hCD, 8'hAB, 1'b0, 16'hABCD, 1'b0});
    tbl.push_back(vec_t'{1'b0, 16'h0F0F, 16'h0000, 1, 8'h77, 8'h00, 1'b0, 16'h0077, 1'b1});
    tbl.push_back(vec_t'{1'b0, 16'h1357, 16'h0000, 2, 8'h11, 8'h22, 1'b1, 16'h2211, 1'b0});
    tbl.push_back(vec_t'{1'b1, 16'hFFFF, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 16'h8001, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1});
    repeat (3) @(negedge clk);
    zero_outputs("reset_state");
    `CHK("reset_sweep", {s_req_ready, s_resp_valid, s_resp_error, s_we, s_re, s_aph,
                         s_stb, s_lane, s_oe, s_bus_out}, 0);
    `CHK("reset_sweep_rdata", s_resp_rdata, 0);
    reset = 1'b0;
    @(negedge clk);
    `CHK("ready_after_reset", req_ready, 1);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    for (int i = 0; i < 8; i++) begin
      v.wr = $urandom_range(0, 1) == 1;
      v.addr = 16'($urandom);
      v.wdata = 16'($urandom);
      v.nacks = v.wr ? 0 : (i == 7 ? 1 : 2);
      v.b0 = 8'($urandom) | 8'h01;
      v.b1 = 8'($urandom) | 8'h01;
      v.stale = $urandom_range(0, 3) == 0;
      v.exp_rdata = v.wr ? 16'h0000 : model_rd(v.b0, v.b1, v.nacks);
      v.exp_err = !v.wr && v.nacks < ND;
      run_vec(v);
    end
    request(1'b1, 16'hC3C3, 16'h5AA5);
    addr_lanes(1'b1, 16'hC3C3);
    repeat (H + 3) @(negedge clk);
    `CHK("mid_lane", {ext_lane, ext_addr_phase, bus_out}, {1'b1, 1'b0, 8'h5A});
    reset = 1'b1;
    @(negedge clk);
    zero_outputs("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    `CHK("ready_after_mid_reset", req_ready, 1);
    run_vec(vec_t'{1'b1, 16'h2468, 16'hBEEF, 0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0});
    `CHK("sweep_ready", s_req_ready, 1);
    s_req_valid = 1'b1;
    s_req_write = 1'b1;
    s_req_addr = 24'h123456;
    s_req_wdata = 32'h89ABCDEF;
    @(negedge clk);
    s_req_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_exp = k < 3 ? lane_of(32'(s_req_addr), k) : lane_of(s_req_wdata, k - 3);
      vecs++;
      if (s_bus_out !== s_exp) begin
        errs++;
        $display("FAIL sweep_bus_direct: got 0x%0h, want 0x%0h at %0t", s_bus_out, s_exp, $time);
      end
      vecs++;
      if (s_lane !== 2'(k < 3 ? k : k - 3)) begin
        errs++;
        $display("FAIL sweep_lane_direct: got %0d at %0t", s_lane, $time);
      end
      `CHK("sweep_bus", s_bus_out, s_exp);
      `CHK("sweep_phase", s_aph, k < 3);
      `CHK("sweep_lane", s_lane, k < 3 ? k : k - 3);
      `CHK("sweep_oe_we", {s_oe, s_we, s_stb, s_resp_valid}, 4'b1110);
      @(negedge clk);
    end
    vecs++;
    if (s_resp_valid !== 1'b1) begin
      errs++;
      $display("FAIL sweep_latency: resp_valid not high at T+8, %0t", $time);
    end
    `CHK("sweep_resp", {s_resp_valid, s_resp_error, s_oe, s_we}, 4'b1000);
    @(negedge clk);
    `CHK("sweep_pulse", {s_resp_valid, s_req_ready}, 2'b01);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
`undef CHK
